// File: rtl/rv_seq_pkg.sv
// Shared types and sizing for the instruction byte sequencer.
// Latency: n/a (type/constant package only).
// Backpressure: n/a.
package rv_seq_pkg;

  // Default pin-side framing: 32-bit instructions moved as four 8-bit bytes.
  localparam int NBYTES = 32 / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  // LOAD: collecting instruction bytes; EXEC: one-cycle datapath step;
  // DRAIN: serializing the captured ALU result back to the host.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Byte-index width for an arbitrary byte count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instr_byte_sequencer.sv
// Purpose: assembles little-endian instruction bytes, fires a one-cycle step
//   into the datapath, then optionally drains the ALU result LSB-first.
// Latency: last byte accepted in cycle N -> step in cycle N+1 -> first result
//   byte valid in cycle N+2 (when drain_en is set during EXEC).
// Backpressure: byte_ready is high only in LOAD (bytes offered elsewhere are
//   dropped); out_byte is held until out_ack, with no limit on the wait.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   abort               synchronous flush back to LOAD (ignored during EXEC)
//   drain_en            sampled in EXEC: 1 = serialize result, 0 = skip DRAIN
//   byte_in/valid/ready host -> sequencer instruction byte stream
//   instr, step         assembled instruction and one-cycle update enable
//   alu_result          datapath result, combinational on instr
//   out_byte/valid/ack  sequencer -> host result byte stream
//   busy                not idle (mid-instruction or outside LOAD)
//   instr_count         retired instruction count, wraps
module instr_byte_sequencer
  import rv_seq_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int BYTE_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               drain_en,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               step,
  input  logic [INSTR_W-1:0] alu_result,
  output logic [BYTE_W-1:0]  out_byte,
  output logic               out_valid,
  input  logic               out_ack,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int NB = INSTR_W / BYTE_W;
  localparam int IW = idx_width(NB);

  seq_state_t         state;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      oidx;
  logic [INSTR_W-1:0] result_q;

  // Status outputs decode straight from registered state, so an async reset
  // clears them immediately without waiting for a clock edge.
  assign byte_ready = (state == LOAD);
  assign step       = (state == EXEC);
  assign out_valid  = (state == DRAIN);
  assign busy       = (state != LOAD) || (idx != '0);

  // Result byte mux; forced to zero when nothing is being offered.
  always_comb begin
    out_byte = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < NB; i++) begin
        if (oidx == IW'(i)) begin
          out_byte = result_q[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      oidx        <= '0;
      instr       <= '0;
      result_q    <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          // abort wins over a coincident byte: the partial instr is kept as
          // is, only the index restarts.
          if (abort) begin
            idx <= '0;
          end else if (byte_valid) begin
            for (int i = 0; i < NB; i++) begin
              if (idx == IW'(i)) begin
                instr[i*BYTE_W +: BYTE_W] <= byte_in;
              end
            end
            if (idx == IW'(NB - 1)) begin
              idx   <= '0;
              state <= EXEC;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        EXEC: begin
          // The datapath commits on this same edge, so alu_result still
          // corresponds to the instruction being retired.
          result_q    <= alu_result;
          instr_count <= instr_count + CNT_W'(1);
          state       <= drain_en ? DRAIN : LOAD;
        end

        DRAIN: begin
          if (abort) begin
            oidx  <= '0;
            state <= LOAD;
          end else if (out_ack) begin
            if (oidx == IW'(NB - 1)) begin
              oidx  <= '0;
              state <= LOAD;
            end else begin
              oidx <= oidx + IW'(1);
            end
          end
        end

        default: begin
          state <= LOAD;
          idx   <= '0;
          oidx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_byte_sequencer.sv
// Directed bench for instr_byte_sequencer: load, drain ordering, skip-drain
// spacing, abort handling, asynchronous reset mid-drain and counter wrap.
module tb_instr_byte_sequencer;

  logic        clk;
  logic        rst;
  logic        abort;
  logic        drain_en;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] instr;
  logic        step;
  logic [31:0] alu_result;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ack;
  logic        busy;
  logic [3:0]  instr_count;

  int n_chk;
  int n_err;
  int cyc;
  int step_cyc[$];
  logic mon_en;
  logic ov_seen;

  instr_byte_sequencer #(
    .INSTR_W(32),
    .BYTE_W (8),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .drain_en   (drain_en),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .instr      (instr),
    .step       (step),
    .alu_result (alu_result),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .busy       (busy),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records step pulses and any out_valid while a window is open.
  always @(negedge clk) begin
    if (mon_en) begin
      if (step) step_cyc.push_back(cyc);
      if (out_valid) ov_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic load_instr(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    mon_en = 1'b0; ov_seen = 1'b0;
    rst = 1'b1; abort = 1'b0; drain_en = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0; out_ack = 1'b0;
    alu_result = 32'h0;
    #1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_step",       {31'd0, step},       32'd0);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_out_byte",   {24'd0, out_byte},   32'd0);
    check("rst_instr",      instr,               32'd0);
    check("rst_count",      {28'd0, instr_count}, 32'd0);
    #6 rst = 1'b0;
    tick();

    // Basic load: 0x93 00 50 00 -> 0x00500093, step the following cycle.
    send_byte(8'h93);
    check("load_busy_mid", {31'd0, busy}, 32'd1);
    check("load_step_mid", {31'd0, step}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h50);
    check("load_step_b3", {31'd0, step}, 32'd0);
    send_byte(8'h00);
    check("load_step",  {31'd0, step}, 32'd1);
    check("load_instr", instr, 32'h0050_0093);
    check("load_exec_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    check("load_step_off", {31'd0, step}, 32'd0);
    check("load_count", {28'd0, instr_count}, 32'd1);
    check("load_idle", {31'd0, busy}, 32'd0);

    // Drain order LSB first, with a stall on the third byte and stray bytes.
    drain_en   = 1'b1;
    alu_result = 32'h1234_5678;
    load_instr(32'h0010_0113);
    check("drn_step", {31'd0, step}, 32'd1);
    tick();
    check("drn_valid", {31'd0, out_valid}, 32'd1);
    check("drn_b0", {24'd0, out_byte}, 32'h78);
    check("drn_ready", {31'd0, byte_ready}, 32'd0);
    out_ack = 1'b1;
    tick();
    check("drn_b1", {24'd0, out_byte}, 32'h56);
    tick();
    check("drn_b2", {24'd0, out_byte}, 32'h34);
    out_ack    = 1'b0;
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drn_hold", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, 8'h34});
    end
    byte_valid = 1'b0;
    out_ack    = 1'b1;
    tick();
    check("drn_b3", {24'd0, out_byte}, 32'h12);
    tick();
    out_ack = 1'b0;
    check("drn_done_valid", {31'd0, out_valid}, 32'd0);
    check("drn_done_ready", {31'd0, byte_ready}, 32'd1);
    check("drn_no_capture", instr, 32'h0010_0113);
    check("drn_busy", {31'd0, busy}, 32'd0);
    check("drn_count", {28'd0, instr_count}, 32'd2);

    // Skip drain: two back-to-back instructions, steps five cycles apart.
    drain_en = 1'b0;
    step_cyc.delete();
    ov_seen = 1'b0;
    mon_en  = 1'b1;
    load_instr(32'hDEAD_BEEF);
    tick();
    load_instr(32'hCAFE_F00D);
    tick();
    tick();
    mon_en = 1'b0;
    check("skip_pulses", step_cyc.size(), 32'd2);
    if (step_cyc.size() == 2)
      check("skip_spacing", step_cyc[1] - step_cyc[0], 32'd5);
    check("skip_no_valid", {31'd0, ov_seen}, 32'd0);
    check("skip_count", {28'd0, instr_count}, 32'd4);
    check("skip_instr", instr, 32'hCAFE_F00D);

    // Abort after two bytes: idle next cycle, partial bytes kept, fresh index.
    send_byte(8'hAA);
    send_byte(8'hBB);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_busy", {31'd0, busy}, 32'd0);
    check("abt_partial", {16'd0, instr[15:0]}, 32'h0000_BBAA);
    check("abt_count", {28'd0, instr_count}, 32'd4);
    load_instr(32'h1122_3344);
    check("abt_fresh_instr", instr, 32'h1122_3344);
    check("abt_fresh_step", {31'd0, step}, 32'd1);
    tick();
    check("abt_fresh_count", {28'd0, instr_count}, 32'd5);

    // Abort held through EXEC (step completes) and into DRAIN (flushed).
    drain_en = 1'b1;
    load_instr(32'h5566_7788);
    abort = 1'b1;
    check("abt_exec_step", {31'd0, step}, 32'd1);
    tick();
    check("abt_exec_count", {28'd0, instr_count}, 32'd6);
    check("abt_exec_drain", {31'd0, out_valid}, 32'd1);
    tick();
    abort = 1'b0;
    check("abt_drain_valid", {31'd0, out_valid}, 32'd0);
    check("abt_drain_ready", {31'd0, byte_ready}, 32'd1);

    // Asynchronous reset between edges while draining.
    load_instr(32'h0000_0013);
    tick();
    check("rmd_valid_pre", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmd_valid", {31'd0, out_valid}, 32'd0);
    check("rmd_step",  {31'd0, step},      32'd0);
    check("rmd_count", {28'd0, instr_count}, 32'd0);
    check("rmd_instr", instr, 32'd0);
    #3 rst = 1'b0;
    tick();
    check("rmd_load_ready", {31'd0, byte_ready}, 32'd1);
    check("rmd_load_busy",  {31'd0, busy},       32'd0);

    // Counter wrap at CNT_W = 4: 16 -> 0, 17 -> 1.
    drain_en = 1'b0;
    for (int n = 0; n < 16; n++) begin
      load_instr(32'h0000_0000 + n);
      tick();
    end
    check("wrap_16", {28'd0, instr_count}, 32'd0);
    load_instr(32'h0000_0099);
    tick();
    check("wrap_17", {28'd0, instr_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_byte_sequencer.md
Name: instr_byte_sequencer

Overview:
Byte-serial front end and step controller for single_cycle_datapath on the 8-bit TinyTapeout pin budget. Assembles 32-bit instructions from little-endian byte writes and fires a one-cycle step enable into the datapath. Captures the 32-bit ALU result and drains it back out one byte at a time over a valid/ack handshake. Sits between tt_um_mario1159_rv32core pins and the datapath.

Parameters:
INSTR_W, 32, instruction and ALU result width; must be a multiple of BYTE_W
BYTE_W, 8, pin-side byte width
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
abort  in  1  synchronous flush back to LOAD
drain_en  in  1  1 = serialize result after each step; 0 = skip DRAIN
byte_in  in  BYTE_W  instruction byte from host
byte_valid  in  1  byte_in valid this cycle
byte_ready  out  1  sequencer accepts a byte this cycle
instr  out  INSTR_W  assembled instruction to datapath
step  out  1  one-cycle datapath update enable
alu_result  in  INSTR_W  datapath ALU result, combinational on instr
out_byte  out  BYTE_W  result byte to host
out_valid  out  1  out_byte valid
out_ack  in  1  host consumed out_byte
busy  out  1  state != LOAD or byte index != 0
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state LOAD, byte index 0, instr 0, result register 0, out_byte 0, out_valid 0, step 0, instr_count 0, busy 0, byte_ready 1.
- NBYTES = INSTR_W/BYTE_W = 4.
- LOAD state:
  - byte_ready = 1.
  - On byte_valid: write byte_in into instr[idx*8 +: 8], little-endian, then idx++.
  - On the 4th accepted byte: idx <= 0 and go to EXEC next cycle.
  - instr updates byte-wise during load; step stays 0, so datapath state is unaffected.
- EXEC state (exactly 1 cycle):
  - step = 1, instr stable.
  - Result register <= alu_result, sampled on the same edge the datapath commits.
  - instr_count++, wrapping 2^CNT_W-1 -> 0.
  - Next state: DRAIN if drain_en = 1, else LOAD.
  - Latency: last byte accepted in cycle N -> step high in cycle N+1.
- DRAIN state:
  - out_valid = 1, out_byte = result[oidx*8 +: 8], oidx starts at 0 (LSB first).
  - On out_ack: oidx++.
  - On the 4th ack: out_valid drops the next cycle, state <= LOAD, oidx <= 0.
  - Without out_ack, out_byte is held indefinitely.
  - byte_ready = 0; byte_valid is ignored, and those bytes are lost.
- out_ack outside DRAIN is ignored.
- byte_valid and out_ack are sampled only in their own states, so simultaneous assertion has no cross-effect.
- abort:
  - In LOAD or DRAIN: state <= LOAD, idx <= 0, oidx <= 0, out_valid <= 0 next cycle. instr keeps its partial contents. instr_count is unchanged.
  - Ignored in EXEC: the step always completes, so the datapath never sees a half-issued instruction.
- drain_en is sampled only in EXEC.
- Reset mid-operation (any state) returns immediately to reset values. No step is emitted.
- busy = (state != LOAD) or (idx != 0).

Decomposition:
- Package rv_seq_pkg:
  - enum seq_state_t {LOAD, EXEC, DRAIN}.
  - Localparams NBYTES and IDX_W = $clog2(NBYTES).
- Flat module, no sub-module.
- The top wrapper maps:
  - byte_in <- ui_in
  - byte_valid <- uio_in[0]
  - out_ack <- uio_in[1]
  - abort <- uio_in[2]
  - drain_en <- uio_in[3]
  - uo_out <- out_byte
  - out_valid, byte_ready, busy -> uio_out[6:4], with uio_oe set accordingly.

Test Plan:
- Basic load: drive bytes 0x93, 0x00, 0x50, 0x00 on consecutive cycles -> instr = 0x00500093; step high exactly one cycle, the cycle after the 4th byte; instr_count = 1.
- Drain order: alu_result stub = 0x12345678, drain_en = 1 -> out_byte sequence 0x78, 0x56, 0x34, 0x12. Withhold out_ack for 5 cycles on byte 2 -> 0x34 held stable. After the 4th ack, byte_ready = 1.
- Skip drain: drain_en = 0, load 2 instructions back-to-back -> two step pulses 5 cycles apart, out_valid never asserts, instr_count = 2.
- Abort: abort after 2 bytes -> busy = 0 next cycle; the next 4 bytes form a fresh instr with no carry-over index. Abort asserted during EXEC -> step still pulses.
- Reset mid-DRAIN: assert rst asynchronously between clock edges -> out_valid = 0, step = 0 and instr_count = 0 immediately. State is LOAD after release.
- Counter wrap: CNT_W = 4, run 17 instructions -> instr_count = 1. Bytes driven during DRAIN -> not captured.
